// File: rtl/cache_controller_wt_if.sv
// CPU load/store port and main-memory port of the write-through cache.
// slave = controller view, master = CPU/memory side view.
interface cache_controller_wt_if #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 10
);
  logic [ADDR-1:0]    cpu_address;
  logic               cpu_read;
  logic               cpu_write;
  logic [WIDTH-1:0]   cpu_write_data;
  logic [WIDTH-1:0]   cpu_read_data;
  logic               done;
  logic               busy;
  logic [ADDR-1:0]    mem_address;
  logic               mem_read_en;
  logic               mem_write_en;
  logic [WIDTH-1:0]   mem_write_data;
  logic               mem_ready;
  logic [4*WIDTH-1:0] mem_read_data;

  modport slave (
    input  cpu_address, cpu_read, cpu_write,
    input  cpu_write_data, mem_ready, mem_read_data,
    output cpu_read_data, done, busy,
    output mem_address, mem_read_en,
    output mem_write_en, mem_write_data
  );

  modport master (
    output cpu_address, cpu_read, cpu_write,
    output cpu_write_data, mem_ready, mem_read_data,
    input  cpu_read_data, done, busy,
    input  mem_address, mem_read_en,
    input  mem_write_en, mem_write_data
  );
endinterface

// File: rtl/cache_controller_wt.sv
// Direct-mapped write-through, no-write-allocate cache controller.
// 4-word lines; read misses fetch the whole line in one transaction.
module cache_controller_wt #(
  parameter int WIDTH     = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int LINES     = 32
) (
  input logic                  clk,
  input logic                  reset,
  cache_controller_wt_if.slave bus
);
  localparam int ADDR = $clog2(MEM_DEPTH);
  localparam int IDX  = $clog2(LINES);
  localparam int TAG  = ADDR - 2 - IDX;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    WRITE
  } state_t;

  state_t state;
  logic   first;

  logic [IDX-1:0] req_idx;
  logic [TAG-1:0] req_tag;
  logic [1:0]     req_off;

  logic [LINES-1:0]   valid_q;
  logic [TAG-1:0]     tag_q  [LINES];
  logic [4*WIDTH-1:0] data_q [LINES];

  logic [1:0]       off;
  logic [IDX-1:0]   idx;
  logic [TAG-1:0]   tg;
  logic             hit;
  logic             rd_hit;
  logic             rd_miss;
  logic             wr_req;
  logic             complete;
  logic             hit_we;
  logic             fill_we;
  logic [WIDTH-1:0] hit_word;
  logic [WIDTH-1:0] fill_word;

  assign off = bus.cpu_address[1:0];
  assign idx = bus.cpu_address[IDX+1:2];
  assign tg  = bus.cpu_address[ADDR-1:IDX+2];
  assign hit = valid_q[idx] && (tag_q[idx] == tg);

  assign rd_hit  = bus.cpu_read && !bus.cpu_write && hit;
  assign rd_miss = bus.cpu_read && !bus.cpu_write && !hit;
  assign wr_req  = bus.cpu_write && !bus.cpu_read;

  // ready may still be high from the previous access in the first cycle
  assign complete = !first && bus.mem_ready;

  assign hit_we  = (state == IDLE) && wr_req && hit;
  assign fill_we = (state == MISS) && complete;

  assign hit_word  = data_q[idx][int'(off)*WIDTH +: WIDTH];
  assign fill_word = bus.mem_read_data[int'(req_off)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (hit_we)
      data_q[idx][int'(off)*WIDTH +: WIDTH] <= bus.cpu_write_data;
    if (fill_we) begin
      data_q[req_idx] <= bus.mem_read_data;
      tag_q[req_idx]  <= req_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      first              <= 1'b0;
      req_idx            <= '0;
      req_tag            <= '0;
      req_off            <= '0;
      valid_q            <= '0;
      bus.cpu_read_data  <= '0;
      bus.done           <= 1'b0;
      bus.busy           <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_read_en    <= 1'b0;
      bus.mem_write_en   <= 1'b0;
      bus.mem_write_data <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          unique case (1'b1)
            rd_hit: begin
              bus.cpu_read_data <= hit_word;
              bus.done          <= 1'b1;
            end
            rd_miss: begin
              req_idx         <= idx;
              req_tag         <= tg;
              req_off         <= off;
              bus.mem_address <= {tg, idx, 2'b00};
              bus.mem_read_en <= 1'b1;
              bus.busy        <= 1'b1;
              first           <= 1'b1;
              state           <= MISS;
            end
            wr_req: begin
              bus.mem_address    <= bus.cpu_address;
              bus.mem_write_data <= bus.cpu_write_data;
              bus.mem_write_en   <= 1'b1;
              bus.busy           <= 1'b1;
              first              <= 1'b1;
              state              <= WRITE;
            end
            default: ;
          endcase
        end
        MISS: begin
          first <= 1'b0;
          if (complete) begin
            valid_q[req_idx]  <= 1'b1;
            bus.cpu_read_data <= fill_word;
            bus.done          <= 1'b1;
            bus.mem_read_en   <= 1'b0;
            bus.busy          <= 1'b0;
            state             <= IDLE;
          end
        end
        WRITE: begin
          first <= 1'b0;
          if (complete) begin
            bus.done         <= 1'b1;
            bus.mem_write_en <= 1'b0;
            bus.busy         <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller_wt.sv
// Bench for cache_controller_wt: directed scenarios plus random
// traffic against a line-presence model over a reference memory.
module tb_cache_controller_wt;
  logic clk   = 1'b0;
  logic reset = 1'b0;

  cache_controller_wt_if bus ();

  cache_controller_wt dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  bit          m_valid [32];
  int          m_tag   [32];

  int ncmp  = 0;
  int nfail = 0;
  int lat   = 1;
  bit stale = 1'b0;
  int cnt   = 0;

  assign bus.mem_read_data = {
    mem[{bus.mem_address[9:2], 2'd3}],
    mem[{bus.mem_address[9:2], 2'd2}],
    mem[{bus.mem_address[9:2], 2'd1}],
    mem[{bus.mem_address[9:2], 2'd0}]
  };

  // memory device: ready after lat cycles, optionally stuck high
  always @(negedge clk) begin
    if (bus.mem_write_en)
      mem[bus.mem_address] = bus.mem_write_data;
    if (bus.mem_read_en || bus.mem_write_en) begin
      bus.mem_ready = (cnt == lat) ? 1'b1 : stale;
      cnt++;
    end else begin
      bus.mem_ready = stale;
      cnt = 0;
    end
  end

  task automatic check(input string name,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic req(input bit wr, input logic [9:0] a,
                     input logic [31:0] d, input bit poke);
    int li    = int'(a[6:2]);
    int tg    = int'(a[9:7]);
    bit hit   = m_valid[li] && (m_tag[li] == tg);
    int waits = 0;
    int expw  = stale ? 2 : lat + 1;
    @(negedge clk);
    bus.cpu_address    = a;
    bus.cpu_read       = !wr;
    bus.cpu_write      = wr;
    bus.cpu_write_data = d;
    @(negedge clk);
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    if (!wr && hit) begin
      check("hit_done", bus.done, 1);
      check("hit_data", bus.cpu_read_data, ref_mem[a]);
      check("hit_nomem",
            {bus.busy, bus.mem_read_en, bus.mem_write_en}, 0);
    end else begin
      check("busy", bus.busy, 1);
      check("rd_en", bus.mem_read_en, !wr);
      check("wr_en", bus.mem_write_en, wr);
      check("mem_addr", bus.mem_address,
            wr ? a : {a[9:2], 2'b00});
      if (wr) check("mem_wdata", bus.mem_write_data, d);
      check("early_done", bus.done, 0);
      if (poke) begin
        bus.cpu_read    = 1'b1;
        bus.cpu_address = a ^ 10'h080;
      end
      while (!bus.done && waits < 100) begin
        @(negedge clk);
        bus.cpu_read = 1'b0;
        waits++;
      end
      check("done_seen", bus.done, 1);
      check("latency", waits, expw);
      check("done_idle",
            {bus.busy, bus.mem_read_en, bus.mem_write_en}, 0);
      if (!wr) check("miss_data", bus.cpu_read_data, ref_mem[a]);
    end
    @(negedge clk);
    check("done_pulse", bus.done, 0);
    if (wr) ref_mem[a] = d;
    else if (!hit) begin
      m_valid[li] = 1'b1;
      m_tag[li]   = tg;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] a;
    bus.cpu_address    = '0;
    bus.cpu_read       = 1'b0;
    bus.cpu_write      = 1'b0;
    bus.cpu_write_data = '0;
    bus.mem_ready      = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hAAAA_0000; mem[5] = 32'hBBBB_1111;
    mem[6] = 32'hCCCC_2222; mem[7] = 32'hDDDD_3333;
    for (int i = 4; i < 8; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;

    #1;
    check("rst_outs", {bus.done, bus.busy, bus.mem_read_en,
                       bus.mem_write_en}, 0);
    check("rst_data", {bus.cpu_read_data, bus.mem_write_data}, 0);
    check("rst_addr", bus.mem_address, 0);
    @(negedge clk);
    reset = 1'b1;

    // cold miss, then hit in same line
    lat = 2;
    req(1'b0, 10'h004, 32'h0, 1'b0);
    req(1'b0, 10'h006, 32'h0, 1'b0);
    // write hit then read back
    lat = 1;
    req(1'b1, 10'h005, 32'hDEAD_BEEF, 1'b0);
    req(1'b0, 10'h005, 32'h0, 1'b0);
    // write miss does not allocate
    req(1'b1, 10'h200, 32'h0000_1234, 1'b0);
    req(1'b0, 10'h200, 32'h0, 1'b0);
    // conflict on index 0
    req(1'b0, 10'h000, 32'h0, 1'b0);
    req(1'b0, 10'h080, 32'h0, 1'b0);
    req(1'b0, 10'h000, 32'h0, 1'b0);
    // stale ready, and a request pulsed while busy
    lat   = 3;
    stale = 1'b1;
    req(1'b0, 10'h024, 32'h0, 1'b1);
    req(1'b1, 10'h025, 32'h5555_AAAA, 1'b0);
    stale = 1'b0;
    req(1'b0, 10'h030, 32'h0, 1'b1);

    // reset in the middle of a miss
    @(negedge clk);
    bus.cpu_address = 10'h040;
    bus.cpu_read    = 1'b1;
    @(negedge clk);
    bus.cpu_read = 1'b0;
    check("pre_rst_rd", bus.mem_read_en, 1);
    reset = 1'b0;
    #1;
    check("mid_rst", {bus.done, bus.busy, bus.mem_read_en,
                      bus.mem_write_en}, 0);
    @(negedge clk);
    check("mid_rst_done", bus.done, 0);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    req(1'b0, 10'h040, 32'h0, 1'b0);
    req(1'b0, 10'h004, 32'h0, 1'b0);

    // simultaneous read and write is ignored
    @(negedge clk);
    bus.cpu_address = 10'h004;
    bus.cpu_read    = 1'b1;
    bus.cpu_write   = 1'b1;
    @(negedge clk);
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    check("illegal", {bus.done, bus.busy, bus.mem_read_en,
                      bus.mem_write_en}, 0);
    req(1'b0, 10'h004, 32'h0, 1'b0);

    // random traffic over a few lines and two tags
    for (int n = 0; n < 150; n++) begin
      a[9:7] = 3'($urandom_range(0, 1));
      a[6:2] = 5'($urandom_range(0, 3));
      a[1:0] = 2'($urandom_range(0, 3));
      lat    = $urandom_range(1, 3);
      stale  = ($urandom_range(0, 7) == 0);
      req($urandom_range(0, 9) < 3, a, $urandom,
          $urandom_range(0, 5) == 0);
    end
    stale = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/cache_controller_wt.md
Name: cache_controller_wt

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller.
- Sits between the CPU load/store port and Main_Memory, and drives the memory's address, read_en, write_en and write_data.
- Read misses fetch a 4-word block in one transaction. Every write is forwarded to memory; a write that hits also updates the cached word.
- Owns the data, tag and valid arrays.

Parameters:
WIDTH, 32, data word width in bits
MEM_DEPTH, 1024, memory depth in words; ADDR = clog2(MEM_DEPTH)
LINES, 32, cache lines of 4 words each; IDX = clog2(LINES), TAG = ADDR-2-IDX

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_address  in  ADDR  word address; bits [1:0] offset, [IDX+1:2] index, upper TAG bits tag
cpu_read  in  1  read request
cpu_write  in  1  write request
cpu_write_data  in  WIDTH  store data
cpu_read_data  out  WIDTH  load data, valid while done=1
done  out  1  one-cycle pulse when a request completes
busy  out  1  request in flight; new requests are ignored
mem_address  out  ADDR  memory address
mem_read_en  out  1  block read request
mem_write_en  out  1  word write request
mem_write_data  out  WIDTH  word to write
mem_ready  in  1  memory completion
mem_read_data  in  4*WIDTH  block; word at offset i is bits [WIDTH*(i+1)-1 : WIDTH*i]

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low.
- During reset:
  - All outputs are 0 and the state is IDLE.
  - All valid bits clear; the data and tag arrays are don't-care.
- All outputs are registered.
- State IDLE (busy=0):
  - Requests are sampled on the rising edge.
  - cpu_read=cpu_write=1 in the same cycle is illegal. It is ignored: no state change, no done.
  - Read hit (valid[idx] && tag[idx]==tag): next cycle cpu_read_data = cached word and done=1. State stays IDLE. Latency 1.
  - Read miss: latch the request. Next cycle: mem_address = {tag,idx,2'b00}, mem_read_en=1, busy=1, state MISS.
  - Write, hit or miss:
    - Latch address and data.
    - On a hit, write cpu_write_data into the cached word in the same edge.
    - Next cycle: mem_address = cpu_address, mem_write_data = data, mem_write_en=1, busy=1, state WRITE.
    - A write miss does not allocate and leaves valid, tag and data unchanged.
- Stale-ready guard: mem_ready is ignored in the first cycle of MISS and of WRITE, because memory ready can remain high from a previous operation. From the second cycle on, mem_ready=1 completes the state.
- State MISS:
  - mem_read_en, mem_address and mem_write_en=0 are held until completion.
  - On the completing edge:
    - data[idx] <= mem_read_data, tag[idx] <= tag, valid[idx] <= 1.
    - cpu_read_data <= word[offset] taken from mem_read_data, not from the array.
    - done=1, mem_read_en=0, busy=0, state IDLE.
- State WRITE:
  - mem_write_en, mem_address and mem_write_data are held until completion.
  - On the completing edge: done=1, mem_write_en=0, busy=0, state IDLE.
- mem_read_en and mem_write_en are never high together.
- Requests while busy=1 are ignored: not queued, no done. The CPU re-issues after done.
- done is high for exactly one cycle per accepted request. The CPU may present a new request in the same cycle that done is high; busy is already 0 then.
- Conflict miss: a MISS completion overwrites the line unconditionally. There is no dirty state because the policy is write-through.
- Reset mid-MISS or mid-WRITE:
  - Immediate return to IDLE, enables drop to 0, no done.
  - The line is not filled and all valid bits are cleared.
- No timeout: if mem_ready never rises, the controller waits indefinitely.

Test Plan:
- Cold read miss: reset, then cpu_read @0x004. Expect mem_read_en=1 with mem_address=0x004. Memory returns {W3,W2,W1,W0}={D,C,B,A} with ready in cycle 3 → done=1, cpu_read_data=A. Then read @0x006 → hit, done one cycle later, cpu_read_data=C, no memory access.
- Write hit: after the fill above, write 0xDEADBEEF @0x005. Expect mem_write_en=1, mem_address=0x005, data 0xDEADBEEF, done after mem_ready. A following read @0x005 hits and returns 0xDEADBEEF.
- Write miss, no allocate: write 0x1234 @0x200. Expect one memory write. A following read @0x200 misses (mem_read_en=1).
- Conflict: fill idx0 from 0x000, then read 0x080 (same index, different tag) → miss and refill. A read of 0x000 then misses again.
- Stale ready and busy: hold mem_ready=1 before a miss. Expect no completion in the first MISS cycle and completion in the second. A cpu_read pulsed while busy=1 produces no done.
- Reset mid-MISS and illegal request: assert reset during MISS → enables 0, no done, then a read of the same address misses. cpu_read=cpu_write=1 in IDLE → no memory activity, no done.
